// File: rtl/heap_sum_unit.sv
// ============================================================================
// Module      : heap_sum_unit
// Description : Sequential accumulator of HEAPS heap counts (ADD total or XOR Nim-sum).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module heap_sum_unit #(
    parameter int WIDTH = 4,
    parameter int HEAPS = 4,
    parameter int SUM_W = WIDTH + $clog2(HEAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int              CNT_W      = $clog2(HEAPS);
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(HEAPS - 1);
    localparam logic [1:0]      S_IDLE     = 2'd0;
    localparam logic [1:0]      S_ACCUM    = 2'd1;
    localparam logic [1:0]      S_DONE     = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             zero_q, zero_d;
    logic [SUM_W-1:0] operand;

    assign operand = SUM_W'(in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        mode_d  = mode_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    acc_d   = '0;
                    count_d = '0;
                    zero_d  = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    // Mode is the copy captured at start, so later toggles of the input are harmless.
                    acc_d  = mode_q ? (acc_q ^ operand) : (acc_q + operand);
                    zero_d = (acc_d == '0);
                    if (count_q == C_LAST) begin
                        count_d = '0;
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                // A simultaneous start is deliberately dropped; only the handshake matters here.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_ACCUM);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_ACCUM) || (state_q == S_DONE);
        result    = acc_q;
        zero      = zero_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_heap_sum_unit.sv
// ============================================================================
// Module      : tb_heap_sum_unit
// Description : Directed plus randomized self-checking bench for heap_sum_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_heap_sum_unit;

    localparam int WIDTH = 4;
    localparam int HEAPS = 4;
    localparam int SUM_W = WIDTH + $clog2(HEAPS);

    typedef int unsigned ops_t [HEAPS];

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] result;
    logic             zero;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    heap_sum_unit #(.WIDTH(WIDTH), .HEAPS(HEAPS), .SUM_W(SUM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int unsigned model(input bit m, input ops_t ops);
        int unsigned r = 0;
        foreach (ops[i]) r = m ? (r ^ ops[i]) : (r + ops[i]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
        mode  = $urandom_range(0, 1);
        chk("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic send(input int unsigned d);
        int budget = 50;
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        while (!in_ready && budget > 0) begin
            step();
            budget--;
        end
        chk("send_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
    endtask

    task automatic wait_out(input string tag);
        int budget = 50;
        while (!out_valid && budget > 0) begin
            step();
            budget--;
        end
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_out_valid_fall"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // gap < 0 means random idle cycles between operands, otherwise a fixed gap.
    task automatic run_txn(input bit m, input ops_t ops, input int gap, input int hold,
                           input string tag);
        int unsigned exp = model(m, ops);
        do_start(m);
        foreach (ops[i]) begin
            int g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            if (i > 0) repeat (g) step();
            send(ops[i]);
        end
        wait_out(tag);
        chk({tag, "_result"}, 32'(result), exp);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp == 0});
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "_hold_out_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_result"}, 32'(result), exp);
            step();
        end
        release_result(tag);
        chk({tag, "_idle_result_held"}, 32'(result), exp);
    endtask

    initial begin
        ops_t ops;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        // in_valid while idle has no effect
        in_valid = 1'b1; in_data = 4'd9;
        repeat (3) step();
        chk("idle_in_valid_busy", {31'd0, busy}, 32'd0);
        chk("idle_in_valid_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        // ADD with back-to-back operands: result visible HEAPS+1 edges after start
        ops = '{3, 4, 5, 0};
        do_start(1'b0);
        foreach (ops[i]) send(ops[i]);
        chk("add_latency_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_result", 32'(result), 32'd12);
        chk("add_zero", {31'd0, zero}, 32'd0);
        release_result("add");

        run_txn(1'b1, '{3, 4, 5, 0}, 0, 0, "xor_a");
        run_txn(1'b1, '{1, 2, 3, 0}, 0, 0, "xor_zero");
        run_txn(1'b0, '{15, 15, 15, 15}, 0, 0, "add_max");
        run_txn(1'b0, '{6, 9, 2, 11}, 1, 10, "backpressure");

        // start re-pulsed mid-accumulation with flipped mode is ignored
        do_start(1'b1);
        send(7);
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        chk("midstart_busy", {31'd0, busy}, 32'd1);
        send(1); send(2); send(4);
        wait_out("midstart");
        chk("midstart_result", 32'(result), 32'd0);
        chk("midstart_zero", {31'd0, zero}, 32'd1);
        release_result("midstart");

        // asynchronous reset mid-accumulation
        do_start(1'b0);
        send(9); send(9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_zero", {31'd0, zero}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_txn(1'b0, '{1, 1, 1, 1}, 0, 0, "post_rst");

        // start together with out_ready in DONE only returns to idle
        ops = '{5, 3, 12, 1};
        do_start(1'b1);
        foreach (ops[i]) send(ops[i]);
        wait_out("done_start");
        start = 1'b1; mode = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        chk("done_start_busy", {31'd0, busy}, 32'd0);
        step();
        chk("done_start_busy2", {31'd0, busy}, 32'd0);
        chk("done_start_result", 32'(result), model(1'b1, ops));

        // randomized transactions
        for (int t = 0; t < 25; t++) begin
            bit m = 1'($urandom_range(0, 1));
            foreach (ops[i]) ops[i] = $urandom_range(0, (1 << WIDTH) - 1);
            run_txn(m, ops, -1, int'($urandom_range(0, 3)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/heap_sum_unit.md
Name: heap_sum_unit

Overview:
Parametrised sequential successor to the team's single-bit combinational adder. It accumulates HEAPS heap counts of WIDTH bits, delivered one per handshake, into a single result. In ADD mode the result is the total stone count; in XOR mode it is the Nim-sum used by the game logic to find winning moves. It sits between the heap register file and the move-decision FSM.

Parameters:
WIDTH, 4, bit width of one heap count.
HEAPS, 4, number of operands per accumulation (>=2).
SUM_W, WIDTH+$clog2(HEAPS), result width (derived; never overflows in ADD mode).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin new accumulation (sampled in IDLE only).
mode  input  1  0 = ADD, 1 = XOR; sampled with start.
in_valid  input  1  in_data valid.
in_ready  output  1  unit accepts in_data this cycle.
in_data  input  WIDTH  heap count operand.
out_valid  output  1  result valid.
out_ready  input  1  consumer takes result.
result  output  SUM_W  accumulated sum / Nim-sum.
zero  output  1  result == 0 (XOR mode: losing position for mover).
busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, count=0, mode_q=0; in_ready=0, out_valid=0, result=0, zero=0, busy=0. Reset mid-accumulation discards partial result.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 -> latch mode_q=mode, acc<=0, count<=0, go ACCUM next cycle. in_valid in IDLE ignored.
- ACCUM: in_ready=1, busy=1. Transfer when in_valid && in_ready. On transfer: ADD: acc <= acc + zero-extended in_data; XOR: acc <= acc ^ zero-extended in_data (upper SUM_W-WIDTH bits stay 0). count++.
- Transfer with count==HEAPS-1 -> DONE next cycle; count resets to 0.
- in_valid gaps allowed; no timeout.
- DONE: out_valid=1, in_ready=0, result=acc held stable while out_ready=0. out_valid && out_ready -> IDLE next cycle, out_valid falls.
- result/zero are registered outputs: valid only while out_valid=1; hold last value in IDLE until next start clears acc.
- zero = (acc == 0), registered with acc.
- Latency: out_valid rises the cycle after the final transfer; minimum start-to-result = HEAPS+1 cycles with in_valid held high.
- start while busy: ignored, mode_q unchanged.
- start and out_ready in same DONE cycle: return to IDLE only; start not honoured (must be re-asserted in IDLE).
- mode changes after start: no effect until next start.
- ADD max value HEAPS*(2^WIDTH-1) fits SUM_W; no wrap required or permitted.

Test Plan:
- ADD, WIDTH=4, HEAPS=4: start, mode=0, feed 3,4,5,0 back-to-back -> out_valid 5 cycles after start, result=12, zero=0.
- XOR, same operands 3,4,5,0 -> result=2, zero=0; then 1,2,3,0 -> result=0, zero=1.
- ADD saturation check: feed 15,15,15,15 -> result=60 (6'b111100), no wrap.
- Backpressure and gaps: in_valid toggled every other cycle, out_ready held low 10 cycles -> in_ready low after 4th transfer, result stable, out_valid held until out_ready=1, then IDLE.
- start pulsed during ACCUM with mode flipped -> ignored; operands 7,1,2,4 in XOR -> result=0 using originally latched mode.
- rst_n low after 2 transfers -> all outputs 0 immediately (asynchronous); new start with 1,1,1,1 ADD -> result=4, no residue of old accumulation.
